// File: rtl/cpu_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding,
// control opcodes, default NOP word and a stack pointer sizing helper.
package cpu_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_t;

    // ctrl_op encodings; codes 6 and 7 behave as OP_SEQ
    localparam logic [2:0] OP_SEQ      = 3'd0;
    localparam logic [2:0] OP_SKIP     = 3'd1;
    localparam logic [2:0] OP_GOTO     = 3'd2;
    localparam logic [2:0] OP_CALL     = 3'd3;
    localparam logic [2:0] OP_RETURN   = 3'd4;
    localparam logic [2:0] OP_ALU_LOAD = 3'd5;

    localparam logic [11:0] DEFAULT_NOP_WORD = 12'h000;

    // A one-entry stack still needs a one-bit pointer register
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Bus bundle between program ROM, the fetch unit and the control FSM.
//
// Handshakes:
//  ROM side: the fetch unit raises rom_req with rom_addr and holds both
//  stable until it samples rom_ack=1 on a rising edge; rom_data is taken
//  in that same cycle. rom_ack while rom_req=0 has no effect.
//  Control side: instr_out is valid while instr_vld=1 and stays put until
//  control samples it with ctrl_acc=1; ctrl_op/alu_data are only looked at
//  in that accepting cycle.
interface cpu_fetch_unit_if #(
    parameter int PC_WIDTH    = 9,
    parameter int INSTR_WIDTH = 12,
    parameter int CALL_WIDTH  = 8
);
    logic                   rom_req;
    logic [PC_WIDTH-1:0]    rom_addr;
    logic                   rom_ack;
    logic [INSTR_WIDTH-1:0] rom_data;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic                   instr_vld;
    logic                   ctrl_acc;
    logic [2:0]             ctrl_op;
    logic [CALL_WIDTH-1:0]  alu_data;
    logic                   flush;

    modport master (
        output rom_req, rom_addr, instr_out, instr_vld,
        input  rom_ack, rom_data, ctrl_acc, ctrl_op, alu_data, flush
    );

    modport slave (
        input  rom_req, rom_addr, instr_out, instr_vld,
        output rom_ack, rom_data, ctrl_acc, ctrl_op, alu_data, flush
    );
endinterface

// File: rtl/cpu_fetch_unit_return_stack.sv
// Circular hardware return stack. Pushing while full overwrites the oldest
// entry; popping while empty still returns the entry below the pointer.
// Both cases raise sticky flags that flag_clr clears (a set wins).
module cpu_fetch_unit_return_stack
    import cpu_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH    = 9,
    parameter int STACK_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic                               flag_clr,
    input  logic [PC_WIDTH-1:0]                push_data,
    output logic [PC_WIDTH-1:0]                pop_data,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   cnt,
    output logic                               ovf,
    output logic                               unf
);
    localparam int PTR_W = ptr_bits(STACK_DEPTH);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(STACK_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_inc;
    logic [PTR_W-1:0]    ptr_dec;
    logic                ovf_set;
    logic                unf_set;

    // Wrapped pointer neighbours and overflow/underflow detection
    always_comb begin
        ptr_inc = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
        ptr_dec = (ptr == '0) ? LAST_PTR : ptr - 1'b1;
        ovf_set = push && (cnt == FULL_CNT);
        unf_set = pop && (cnt == '0);
    end

    assign pop_data = mem[ptr_dec];

    // Entry storage, pointer, saturating count and sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (push) begin
                mem[ptr] <= push_data;
                ptr      <= ptr_inc;
                if (cnt != FULL_CNT) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (pop) begin
                ptr <= ptr_dec;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
            ovf <= ovf_set || (ovf && !flag_clr);
            unf <= unf_set || (unf && !flag_clr);
        end
    end
endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch unit: PC, instruction register, NOP/skip insertion,
// ROM req/ack handshake and valid/accept handoff to the control FSM.
module cpu_fetch_unit
    import cpu_fetch_unit_pkg::*;
#(
    parameter int                     PC_WIDTH     = 9,
    parameter int                     INSTR_WIDTH  = 12,
    parameter int                     STACK_DEPTH  = 2,
    parameter int                     LIT_WIDTH    = 9,
    parameter int                     CALL_WIDTH   = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 9'h1FF,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD     = DEFAULT_NOP_WORD
) (
    input  logic                             clk,
    input  logic                             rst,
    cpu_fetch_unit_if.master                 bus,
    input  logic                             flag_clr,
    output logic [PC_WIDTH-1:0]              pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_cnt,
    output logic                             stk_ovf,
    output logic                             stk_unf,
    output fetch_state_t                     fsm_state
);
    fetch_state_t           state;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [INSTR_WIDTH-1:0] ir;
    logic                   rom_req_q;
    logic                   instr_vld_q;
    logic                   nop_pending;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [PC_WIDTH-1:0]    pop_data;

    assign bus.rom_req   = rom_req_q;
    assign bus.rom_addr  = pc;
    assign bus.instr_out = ir;
    assign bus.instr_vld = instr_vld_q;
    assign pc_out        = pc;
    assign fsm_state     = state;

    // Next-PC mux for the op control applies when it accepts an instruction
    always_comb begin
        accept  = (state == ST_ISSUE) && bus.ctrl_acc;
        push    = accept && (bus.ctrl_op == OP_CALL);
        pop     = accept && (bus.ctrl_op == OP_RETURN);
        pc_next = pc;
        case (bus.ctrl_op)
            OP_SEQ:      pc_next = pc;
            OP_GOTO:     pc_next = PC_WIDTH'(ir[LIT_WIDTH-1:0]);
            OP_CALL:     pc_next = PC_WIDTH'(ir[CALL_WIDTH-1:0]);
            OP_RETURN:   pc_next = pop_data;
            OP_ALU_LOAD: pc_next = PC_WIDTH'(bus.alu_data);
            default:     pc_next = pc;
        endcase
    end

    // pc already points past the instruction in ISSUE, so it is the return address
    cpu_fetch_unit_return_stack #(
        .PC_WIDTH   (PC_WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flag_clr (flag_clr),
        .push_data(pc),
        .pop_data (pop_data),
        .cnt      (stack_cnt),
        .ovf      (stk_ovf),
        .unf      (stk_unf)
    );

    // Fetch/issue FSM with registered handshake outputs, PC, IR and NOP marker
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_VECTOR;
            ir          <= NOP_WORD;
            rom_req_q   <= 1'b0;
            instr_vld_q <= 1'b0;
            nop_pending <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state     <= ST_FETCH;
                    rom_req_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (rom_req_q && bus.rom_ack) begin
                        // a flush arriving with the ack already targets this word
                        ir          <= (nop_pending || bus.flush) ? NOP_WORD : bus.rom_data;
                        nop_pending <= 1'b0;
                        pc          <= pc + 1'b1;
                        rom_req_q   <= 1'b0;
                        instr_vld_q <= 1'b1;
                        state       <= ST_ISSUE;
                    end else if (bus.flush) begin
                        nop_pending <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.ctrl_acc) begin
                        pc          <= pc_next;
                        instr_vld_q <= 1'b0;
                        rom_req_q   <= 1'b1;
                        state       <= ST_FETCH;
                        if ((bus.ctrl_op == OP_SKIP) || bus.flush) begin
                            nop_pending <= 1'b1;
                        end
                    end else if (bus.flush) begin
                        ir <= NOP_WORD;
                    end
                end
                default: begin
                    state       <= ST_BOOT;
                    rom_req_q   <= 1'b0;
                    instr_vld_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: a ROM/control driver walks
// instruction sequences, expected issued words go through exp_q.
module tb_cpu_fetch_unit;
    import cpu_fetch_unit_pkg::*;

    localparam int PC_W = 9;
    localparam int IW   = 12;
    localparam int CW   = 8;
    localparam logic [IW-1:0] NOP = 12'h000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flag_clr = 1'b0;
    logic [PC_W-1:0] pc_out;
    logic [1:0]   stack_cnt;
    logic         stk_ovf;
    logic         stk_unf;
    fetch_state_t fsm_state;

    logic [IW-1:0] exp_q[$];
    int checks = 0;
    int fails  = 0;

    cpu_fetch_unit_if #(.PC_WIDTH(PC_W), .INSTR_WIDTH(IW), .CALL_WIDTH(CW)) bus ();

    cpu_fetch_unit dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flag_clr (flag_clr),
        .pc_out   (pc_out),
        .stack_cnt(stack_cnt),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf),
        .fsm_state(fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    // hard stop if something hangs
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full fetch + issue + accept of the instruction at addr
    task automatic do_instr(input logic [PC_W-1:0] addr, input logic [IW-1:0] word,
                            input int lat, input bit nop_exp, input logic [2:0] op,
                            input logic [CW-1:0] alu, input bit flush_issue);
        int waited;
        logic [IW-1:0] exp_w;
        logic [PC_W-1:0] exp_pc;
        waited = 0;
        while (bus.rom_req !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (bus.rom_req !== 1'b1) begin
            fails++;
            $display("FAIL req_timeout addr=%h: rom_req=%b required 1", addr, bus.rom_req);
            return;
        end
        checks++;
        if (bus.rom_addr !== addr) begin
            fails++;
            $display("FAIL rom_addr: got %h expected %h", bus.rom_addr, addr);
        end
        for (int i = 0; i < lat; i++) begin
            step();
            checks++;
            if (bus.rom_req !== 1'b1 || bus.rom_addr !== addr || bus.instr_vld !== 1'b0) begin
                fails++;
                $display("FAIL rom_hold cycle %0d: req=%b addr=%h vld=%b expected req=1 addr=%h vld=0",
                         i, bus.rom_req, bus.rom_addr, bus.instr_vld, addr);
            end
        end
        bus.rom_ack  = 1'b1;
        bus.rom_data = word;
        exp_q.push_back(nop_exp ? NOP : word);
        step();
        bus.rom_ack  = 1'b0;
        bus.rom_data = IW'($urandom_range(0, 4095));
        checks++;
        if (bus.instr_vld !== 1'b1 || bus.rom_req !== 1'b0) begin
            fails++;
            $display("FAIL issue_vld addr=%h: vld=%b req=%b expected vld=1 req=0",
                     addr, bus.instr_vld, bus.rom_req);
        end
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.instr_out !== exp_w) begin
            fails++;
            $display("FAIL instr_out addr=%h: got %h expected %h", addr, bus.instr_out, exp_w);
        end
        exp_pc = addr + 9'd1;
        checks++;
        if (pc_out !== exp_pc) begin
            fails++;
            $display("FAIL pc_inc: got %h expected %h", pc_out, exp_pc);
        end
        if (flush_issue) begin
            bus.flush = 1'b1;
            step();
            bus.flush = 1'b0;
            checks++;
            if (bus.instr_out !== NOP || bus.instr_vld !== 1'b1) begin
                fails++;
                $display("FAIL flush_issue: instr=%h vld=%b expected instr=%h vld=1",
                         bus.instr_out, bus.instr_vld, NOP);
            end
        end
        bus.ctrl_acc = 1'b1;
        bus.ctrl_op  = op;
        bus.alu_data = alu;
        step();
        bus.ctrl_acc = 1'b0;
        bus.ctrl_op  = OP_SEQ;
        checks++;
        if (bus.instr_vld !== 1'b0 || bus.rom_req !== 1'b1) begin
            fails++;
            $display("FAIL accept addr=%h: vld=%b req=%b expected vld=0 req=1",
                     addr, bus.instr_vld, bus.rom_req);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.rom_req !== 1'b0 || bus.rom_addr !== 9'h1FF || pc_out !== 9'h1FF ||
            bus.instr_out !== NOP || bus.instr_vld !== 1'b0 || stack_cnt !== 2'd0 ||
            stk_ovf !== 1'b0 || stk_unf !== 1'b0 || fsm_state !== ST_BOOT) begin
            fails++;
            $display("FAIL %s: req=%b addr=%h pc=%h instr=%h vld=%b cnt=%0d ovf=%b unf=%b st=%0d expected 0 1ff 1ff 000 0 0 0 0 0",
                     tag, bus.rom_req, bus.rom_addr, pc_out, bus.instr_out, bus.instr_vld,
                     stack_cnt, stk_ovf, stk_unf, fsm_state);
        end
    endtask

    task automatic check_stack(input string tag, input logic [PC_W-1:0] pc_exp,
                               input logic [1:0] cnt_exp, input bit ovf_exp, input bit unf_exp);
        checks++;
        if (pc_out !== pc_exp || stack_cnt !== cnt_exp || stk_ovf !== ovf_exp || stk_unf !== unf_exp) begin
            fails++;
            $display("FAIL %s: pc=%h cnt=%0d ovf=%b unf=%b expected pc=%h cnt=%0d ovf=%b unf=%b",
                     tag, pc_out, stack_cnt, stk_ovf, stk_unf, pc_exp, cnt_exp, ovf_exp, unf_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b1;
        step();
        checks++;
        if (fsm_state !== ST_FETCH || bus.rom_req !== 1'b1 || bus.rom_addr !== 9'h1FF) begin
            fails++;
            $display("FAIL boot_to_fetch: st=%0d req=%b addr=%h expected st=1 req=1 addr=1ff",
                     fsm_state, bus.rom_req, bus.rom_addr);
        end
    endtask

    task automatic test_sequential();
        do_instr(9'h1FF, IW'($urandom_range(1, 4095)), 0, 1'b0, OP_SEQ, 8'h00, 1'b0);
        do_instr(9'h000, IW'($urandom_range(1, 4095)), 0, 1'b0, OP_SEQ, 8'h00, 1'b0);
        do_instr(9'h001, IW'($urandom_range(1, 4095)), 0, 1'b0, OP_SEQ, 8'h00, 1'b0);
    endtask

    task automatic test_rom_latency();
        // GOTO with junk in the upper bits: literal is ir[8:0] = 0x010
        do_instr(9'h002, 12'hA10, 3, 1'b0, OP_GOTO, 8'h00, 1'b0);
        check_stack("goto_target", 9'h010, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_call_return();
        do_instr(9'h010, 12'hF05, 0, 1'b0, OP_CALL, 8'h00, 1'b0);
        check_stack("call_0x05", 9'h005, 2'd1, 1'b0, 1'b0);
        do_instr(9'h005, IW'($urandom_range(0, 4095)), 0, 1'b0, OP_RETURN, 8'h00, 1'b0);
        check_stack("return_0x011", 9'h011, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_stack_wrap();
        do_instr(9'h011, 12'h030, 0, 1'b0, OP_CALL, 8'h00, 1'b0);
        check_stack("call_lvl1", 9'h030, 2'd1, 1'b0, 1'b0);
        do_instr(9'h030, 12'h040, 0, 1'b0, OP_CALL, 8'h00, 1'b0);
        check_stack("call_lvl2", 9'h040, 2'd2, 1'b0, 1'b0);
        do_instr(9'h040, 12'h050, 1, 1'b0, OP_CALL, 8'h00, 1'b0);
        check_stack("call_ovf", 9'h050, 2'd2, 1'b1, 1'b0);
        do_instr(9'h050, IW'($urandom_range(0, 4095)), 0, 1'b0, OP_RETURN, 8'h00, 1'b0);
        check_stack("ret_lvl2", 9'h041, 2'd1, 1'b1, 1'b0);
        do_instr(9'h041, IW'($urandom_range(0, 4095)), 0, 1'b0, OP_RETURN, 8'h00, 1'b0);
        check_stack("ret_lvl1", 9'h031, 2'd0, 1'b1, 1'b0);
        do_instr(9'h031, IW'($urandom_range(0, 4095)), 0, 1'b0, OP_RETURN, 8'h00, 1'b0);
        check_stack("ret_unf_wrap", 9'h041, 2'd0, 1'b1, 1'b1);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check_stack("flag_clr", 9'h041, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_skip_flush();
        do_instr(9'h041, 12'h020, 0, 1'b0, OP_GOTO, 8'h00, 1'b0);
        do_instr(9'h020, IW'($urandom_range(0, 4095)), 0, 1'b0, OP_SKIP, 8'h00, 1'b0);
        do_instr(9'h021, IW'($urandom_range(1, 4095)), 2, 1'b1, OP_SEQ, 8'h00, 1'b0);
        do_instr(9'h022, IW'($urandom_range(1, 4095)), 0, 1'b0, OP_SEQ, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid_fetch();
        step();
        step();
        checks++;
        if (bus.rom_req !== 1'b1 || bus.rom_addr !== 9'h023) begin
            fails++;
            $display("FAIL wait_before_reset: req=%b addr=%h expected req=1 addr=023",
                     bus.rom_req, bus.rom_addr);
        end
        rst = 1'b0;
        #1;
        check_reset_values("reset_mid_fetch");
        step();
        rst = 1'b1;
        do_instr(9'h1FF, IW'($urandom_range(0, 4095)), 0, 1'b0, OP_ALU_LOAD, 8'hAB, 1'b0);
        check_stack("alu_load", 9'h0AB, 2'd0, 1'b0, 1'b0);
        do_instr(9'h0AB, IW'($urandom_range(1, 4095)), 1, 1'b0, OP_SEQ, 8'h00, 1'b0);
    endtask

    // main sequence
    initial begin
        bus.rom_ack  = 1'b0;
        bus.rom_data = '0;
        bus.ctrl_acc = 1'b0;
        bus.ctrl_op  = OP_SEQ;
        bus.alu_data = '0;
        bus.flush    = 1'b0;
        #2;
        test_reset();
        test_sequential();
        test_rom_latency();
        test_call_return();
        test_stack_wrap();
        test_skip_flush();
        test_reset_mid_fetch();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
